// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display.
// Holds the active-low segment table, the blank pattern and a clog2 helper.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // {dp,g,f,e,d,c,b,a}, active-low, dp held off
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex7seg.sv
// Hex nibble to active-low seven-segment pattern.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed hex display of a selectable debug word.
// The word is snapshotted once per frame so digits never tear.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int N_CH        = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int SEL_W       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*4*N_DIGITS-1:0] ch_data,
    input  logic [SEL_W-1:0]           ch_sel,
    input  logic                       lz_blank,
    input  logic                       freeze,
    output logic [N_DIGITS-1:0]        AN,
    output logic [7:0]                 SEG
);

    localparam int W     = 4 * N_DIGITS;
    localparam int PRE_W = clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [W-1:0]        snap_q, snap_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                tick;
    logic                frame_start;
    logic [W-1:0]        chan_word;
    logic [N_DIGITS-1:0] blank_mask;
    logic                zero_run;
    logic [3:0]          nib;
    logic                digit_blank;
    logic [7:0]          dec_seg;

    assign tick        = (pre_q == PRE_W'(REFRESH_DIV - 1));
    assign frame_start = tick && (idx_q == IDX_W'(N_DIGITS - 1));

    // Out-of-range selects fall back to channel 0
    always_comb begin
        chan_word = ch_data[W-1:0];
        for (int k = 1; k < N_CH; k++) begin
            if (32'(ch_sel) == k) chan_word = ch_data[k*W +: W];
        end
    end

    always_comb begin
        pre_d  = tick ? '0 : pre_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        if (frame_start && !freeze) snap_d = chan_word;
    end

    // A digit blanks when it and every more significant nibble are zero
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (snap_q[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run & (i != 0);
        end
    end

    always_comb begin
        nib         = 4'h0;
        digit_blank = 1'b0;
        an_d        = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (32'(idx_q) == i) begin
                nib         = snap_q[4*i +: 4];
                digit_blank = lz_blank & blank_mask[i];
                an_d[i]     = 1'b0;
            end
        end
        if (tick) an_d = '1;
    end

    hex7seg u_hex7seg (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // The cycle after tick is dead time for ghost suppression
    always_comb begin
        seg_d = digit_blank ? SEG_BLANK : dec_seg;
        if (tick) seg_d = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (4 digits, 3 channels, div 4).
module tb_seg7_scan_display;

    localparam int ND  = 4;
    localparam int NC  = 3;
    localparam int DIV = 4;
    localparam int SW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC*16-1:0] ch_data;
    logic [SW-1:0]   ch_sel;
    logic            lz_blank;
    logic            freeze;
    logic [ND-1:0]   an;
    logic [7:0]      seg;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .N_DIGITS    (ND),
        .N_CH        (NC),
        .REFRESH_DIV (DIV),
        .SEL_W       (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_data  (ch_data),
        .ch_sel   (ch_sel),
        .lz_blank (lz_blank),
        .freeze   (freeze),
        .AN       (an),
        .SEG      (seg)
    );

    localparam logic [7:0] HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          m_pre  = 0;
    int          m_idx  = 0;
    logic [15:0] m_snap = 16'h0;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model predicts the registered outputs for the coming edge
    task automatic step();
        exp_t        e;
        logic        tk;
        logic [3:0]  nb;
        logic [15:0] upper;
        if (rst) begin
            e      = '{an: 4'hF, seg: 8'hFF};
            m_pre  = 0;
            m_idx  = 0;
            m_snap = 16'h0;
        end else begin
            tk = (m_pre == DIV - 1);
            if (tk) begin
                e = '{an: 4'hF, seg: 8'hFF};
            end else begin
                nb    = m_snap[4*m_idx +: 4];
                upper = m_snap >> (4 * m_idx);
                e.an  = 4'hF & ~(4'b0001 << m_idx);
                e.seg = (lz_blank && m_idx != 0 && upper == 16'h0)
                        ? 8'hFF : HEX[nb];
            end
            if (tk && m_idx == ND - 1 && !freeze) begin
                if (int'(ch_sel) < NC)
                    m_snap = ch_data[int'(ch_sel)*16 +: 16];
                else
                    m_snap = ch_data[15:0];
            end
            m_pre = tk ? 0 : m_pre + 1;
            if (tk) m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("sb_an", {4'h0, an}, {4'h0, e.an});
        check("sb_seg", seg, e.seg);
    endtask

    // Bounded wait for a digit slot, then check its segment literal
    task automatic expect_slot(input string tag, input logic [3:0] want_an,
                               input logic [7:0] want_seg);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (an === want_an) found = 1'b1;
        end
        check({tag, "_found"}, {7'h0, found}, 8'h01);
        check({tag, "_seg"}, seg, want_seg);
    endtask

    initial begin
        rst      = 1'b1;
        ch_data  = '0;
        ch_sel   = '0;
        lz_blank = 1'b0;
        freeze   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            ch_data  = {$urandom, $urandom};
            ch_sel   = SW'($urandom_range(0, 3));
            lz_blank = 1'($urandom_range(0, 1));
            freeze   = 1'($urandom_range(0, 1));
            step();
            check("rst_an", {4'h0, an}, 8'h0F);
            check("rst_seg", seg, 8'hFF);
        end

        rst      = 1'b0;
        ch_data  = {16'hABCD, 16'h5555, 16'h1234};
        ch_sel   = 2'd0;
        lz_blank = 1'b0;
        freeze   = 1'b0;

        expect_slot("first_d0", 4'hE, 8'hC0);
        expect_slot("first_d1", 4'hD, 8'hC0);
        expect_slot("first_d2", 4'hB, 8'hC0);
        expect_slot("first_d3", 4'h7, 8'hC0);

        expect_slot("scan_d0", 4'hE, 8'h99);
        expect_slot("scan_d1", 4'hD, 8'hB0);
        expect_slot("scan_d2", 4'hB, 8'hA4);
        expect_slot("scan_d3", 4'h7, 8'hF9);
        expect_slot("dead", 4'hF, 8'hFF);
        expect_slot("scan2_d0", 4'hE, 8'h99);

        ch_sel = 2'd2;
        expect_slot("tear_d1", 4'hD, 8'hB0);
        expect_slot("tear_d2", 4'hB, 8'hA4);
        expect_slot("tear_d3", 4'h7, 8'hF9);
        expect_slot("ch2_d0", 4'hE, 8'hA1);
        expect_slot("ch2_d1", 4'hD, 8'hC6);
        expect_slot("ch2_d2", 4'hB, 8'h83);
        expect_slot("ch2_d3", 4'h7, 8'h88);

        ch_sel = 2'd3;
        expect_slot("oor_d0", 4'hE, 8'h99);
        expect_slot("oor_d1", 4'hD, 8'hB0);

        freeze         = 1'b1;
        ch_data[15:0]  = 16'hFFFF;
        for (int i = 0; i < 3 * ND * DIV; i++) step();
        expect_slot("frz_d0", 4'hE, 8'h99);
        expect_slot("frz_d1", 4'hD, 8'hB0);
        freeze = 1'b0;
        expect_slot("thaw_d2", 4'hB, 8'hA4);
        expect_slot("thaw_d3", 4'h7, 8'hF9);
        expect_slot("new_d0", 4'hE, 8'h8E);
        expect_slot("new_d1", 4'hD, 8'h8E);
        expect_slot("new_d2", 4'hB, 8'h8E);
        expect_slot("new_d3", 4'h7, 8'h8E);

        lz_blank      = 1'b1;
        ch_data[15:0] = 16'h0050;
        expect_slot("lz50_d0", 4'hE, 8'hC0);
        expect_slot("lz50_d1", 4'hD, 8'h92);
        expect_slot("lz50_d2", 4'hB, 8'hFF);
        expect_slot("lz50_d3", 4'h7, 8'hFF);

        ch_data[15:0] = 16'h0000;
        expect_slot("lz0_d0", 4'hE, 8'hC0);
        expect_slot("lz0_d1", 4'hD, 8'hFF);
        expect_slot("lz0_d2", 4'hB, 8'hFF);
        expect_slot("lz0_d3", 4'h7, 8'hFF);

        lz_blank = 1'b0;
        expect_slot("nolz_d0", 4'hE, 8'hC0);
        expect_slot("nolz_d1", 4'hD, 8'hC0);

        rst = 1'b1;
        step();
        check("midrst_an", {4'h0, an}, 8'h0F);
        check("midrst_seg", seg, 8'hFF);
        rst = 1'b0;
        expect_slot("post_d0", 4'hE, 8'hC0);
        for (int i = 0; i < 2 * ND * DIV; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
